cam_capture_gen: RTL and testbench
==================================

# cam_capture_gen

Parametrised OV7670 pixel-capture front end, successor to the fixed 640x480 RGB444 capture block. Sits between the camera pins (pclk, vsync, href, 8-bit data) and the frame-buffer write port. Adds:

- a configurable frame size;
- a run-time RGB444/RGB565 mode;
- internal start-up frame skipping;
- per-line/per-frame geometry checking, with write suppression on overrun.

## Interface

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- SKIP_FRAMES, 2, complete frames discarded after reset before capture is allowed (0 = none).

Ports (clock and reset first):
- pclk  in  1  camera pixel clock; all logic on rising edge. One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous, active-low reset.
- vsync  in  1  camera vertical sync, high during vertical blanking.
- href  in  1  camera line-valid, synchronous to pclk.
- pix_data_in  in  8  camera data byte.
- enable  in  1  capture permission, sampled at frame start.
- mode  in  1  0 = RGB444, 1 = RGB565; latched at frame start.
- pix_addr  out  ADDR_W  write address, valid with wr.
- pix_data_out  out  16  assembled pixel, valid with wr.
- wr  out  1  one-cycle write strobe per accepted pixel.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- frame_err  out  1  geometry-error status of the last captured frame; updated with frame_done.

## Operation

- **Reset values:** all outputs 0, state SKIP, skip count 0, byte phase 0.
  - If SKIP_FRAMES = 0, reset enters IDLE.
  - rst_n low mid-frame aborts the frame with no frame_done.
- **vsync edge detect:** vsync passes through two registers (v1, v2).
  - start_frame = v2 & ~v1 (falling edge).
  - end_frame = ~v2 & v1 (rising edge).
- **href edge detect:** href is registered once (h1); line_end = h1 & ~href.
- **SKIP:** each end_frame increments the skip count. The end_frame that brings the count to SKIP_FRAMES moves to IDLE.
- **IDLE:** on start_frame with enable = 1 → CAPTURE. On that transition:
  - latch mode;
  - clear address, column, line, phase and the error accumulator.
  - start_frame with enable = 0: stay in IDLE.
- **CAPTURE, per byte while href = 1:**
  - phase 0: store byte as hi; phase ← 1.
  - phase 1: form the pixel; phase ← 0.
- **Pixel format:**
  - RGB444 → {4'b0, hi[3:0], byte[7:0]}.
  - RGB565 → {hi, byte}.
- **Pixel write:** a pixel is written when column < H_ACTIVE and line < V_ACTIVE.
  - wr = 1, pix_addr = current address; address then increments.
  - Otherwise wr stays 0 and the error accumulator is set.
  - The column counter increments on every formed pixel.
- **line_end in CAPTURE:**
  - line count increments (saturating at V_ACTIVE);
  - column ← 0, phase ← 0;
  - if column ≠ H_ACTIVE or phase was 1 (odd byte), set the error accumulator. A lone odd byte is discarded.
- **end_frame in CAPTURE:**
  - frame_done = 1 for one cycle;
  - frame_err = accumulator | (line count ≠ V_ACTIVE);
  - state → IDLE.
- **enable deasserted mid-frame:** the current frame completes normally; the next frame is not started.
- **mode changes mid-frame:** ignored until the next start_frame.
- **Address range:** the address never exceeds H_ACTIVE*V_ACTIVE−1, because writes beyond geometry are suppressed. No wrap-around occurs.

## Timing

- wr, pix_addr and pix_data_out are registered. They are asserted on the pclk edge after the second byte of a pixel is sampled (latency 1 cycle from byte 2).
- wr is never high on two consecutive cycles; the minimum spacing is 2 cycles.
- start_frame/end_frame follow the vsync transition by 2 cycles. href and data are used directly, with no synchroniser, because they are pclk-synchronous.
- The frame_done pulse is 2 cycles after the vsync rise. frame_err is valid on the same cycle as frame_done and holds until the next frame_done or reset.
- An href rise in the same cycle as end_frame: end_frame wins; the byte is ignored.

## Test plan

Parameters for all scenarios: H_ACTIVE = 4, V_ACTIVE = 2, SKIP_FRAMES = 1.

- Reset, then 1 full frame → no wr. A second frame (enable = 1, mode = 0, bytes 0x0A,0x5C per pixel) → 8 wr pulses, addr 0..7, data 0x0A5C, frame_done with frame_err = 0.
- mode = 1, bytes 0xF8,0x1F → data 0xF81F. Toggle mode mid-frame → format unchanged until the next frame.
- Line of 5 pixels → 4 writes only on that line, frame_err = 1. Line of 3 pixels → 3 writes, frame_err = 1.
- Odd byte count (9 bytes) on a line → 4 writes, last byte dropped, frame_err = 1.
- Frame with 3 lines → 8 writes, max addr 7, frame_err = 1. Frame with 1 line → 4 writes, frame_err = 1.
- enable = 0 at start_frame → no wr, no frame_done. rst_n low mid-CAPTURE → outputs 0, state SKIP, and the next frame is skipped.

Source files
------------

// File: rtl/cam_capture_gen.sv
// ---------------------------------------------------------------------------
// cam_capture_gen
//
// OV7670 pixel-capture front end. Turns the camera byte stream (two bytes
// per pixel, framed by vsync and href) into 16-bit frame-buffer writes.
// The frame size is configurable, and the pixel format is selectable at run
// time as RGB444 or RGB565. The block discards a number of complete frames
// after reset while the sensor settles. Each captured frame gets a geometry
// check, and writes outside the configured frame size are suppressed.
//
// Parameters
//   H_ACTIVE     pixels per line
//   V_ACTIVE     lines per frame
//   ADDR_W       frame-buffer address width (2**ADDR_W >= H_ACTIVE*V_ACTIVE)
//   SKIP_FRAMES  complete frames discarded after reset (0 = none)
//
// Ports
//   pclk          camera pixel clock, everything on its rising edge
//   rst_n         synchronous active-low reset
//   vsync         camera vertical sync, high during vertical blanking
//   href          camera line-valid, already synchronous to pclk
//   pix_data_in   camera data byte
//   enable        capture permission, sampled at frame start
//   mode          0 = RGB444, 1 = RGB565, latched at frame start
//   pix_addr      frame-buffer write address, valid with wr
//   pix_data_out  assembled 16-bit pixel, valid with wr
//   wr            one-cycle write strobe per accepted pixel
//   frame_done    one-cycle pulse at the end of each captured frame
//   frame_err     geometry error of the last captured frame (with frame_done)
// ---------------------------------------------------------------------------
module cam_capture_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 19,
    parameter int SKIP_FRAMES = 2
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        pix_data_in,
    input  logic              enable,
    input  logic              mode,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [15:0]       pix_data_out,
    output logic              wr,
    output logic              frame_done,
    output logic              frame_err
);

    // The column counter needs room for one value past H_ACTIVE. That value
    // lets an over-long line stay distinguishable from an exact one, and the
    // counter saturates there.
    localparam int COL_W  = $clog2(H_ACTIVE + 2);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_SAT   = COL_W'(H_ACTIVE + 1);
    localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_ACTIVE);
    localparam logic [SKIP_W-1:0] SKIP_LAST =
        SKIP_W'((SKIP_FRAMES > 0) ? (SKIP_FRAMES - 1) : 0);

    typedef enum logic [1:0] {
        ST_SKIP,
        ST_IDLE,
        ST_CAPTURE
    } state_t;

    localparam state_t RESET_STATE = (SKIP_FRAMES == 0) ? ST_IDLE : ST_SKIP;

    // vsync / href history
    logic              v1_q;
    logic              v2_q;
    logic              h1_q;

    // control state
    state_t            state_q;
    logic [SKIP_W-1:0] skip_cnt_q;
    logic              mode_q;
    logic              phase_q;
    logic [7:0]        hi_q;
    logic [COL_W-1:0]  col_q;
    logic [LINE_W-1:0] line_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_acc_q;

    // registered outputs
    logic              wr_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic [15:0]       pix_data_q;
    logic              frame_done_q;
    logic              frame_err_q;

    // combinational helpers
    logic              start_frame;
    logic              end_frame;
    logic              line_end;
    logic              in_geom;
    logic [15:0]       pixel_d;
    logic [COL_W-1:0]  col_inc_d;
    logic [LINE_W-1:0] line_inc_d;

    // A vsync fall opens a frame and a vsync rise closes it. href and data
    // are already pclk-synchronous, so href only needs one history bit to
    // detect the end of a line.
    assign start_frame = v2_q & ~v1_q;
    assign end_frame   = ~v2_q & v1_q;
    assign line_end    = h1_q & ~href;

    // Pixel assembly uses the stored high byte and the byte now on the bus.
    // RGB444 keeps only the low nibble of the first byte.
    assign pixel_d = mode_q ? {hi_q, pix_data_in}
                            : {4'b0000, hi_q[3:0], pix_data_in};

    assign in_geom    = (col_q < COL_FULL) && (line_q < LINE_FULL);
    assign col_inc_d  = (col_q == COL_SAT) ? COL_SAT : col_q + COL_W'(1);
    assign line_inc_d = (line_q == LINE_FULL) ? LINE_FULL : line_q + LINE_W'(1);

    // The edge-detect history samples continuously, even during reset. A
    // vsync level that is held across reset therefore cannot look like a
    // fresh edge afterwards. All control state and outputs use the
    // synchronous reset. The capture FSM moves between skipping start-up
    // frames, waiting for a permitted frame start, and capturing pixels.
    always_ff @(posedge pclk) begin
        v1_q <= vsync;
        v2_q <= v1_q;
        h1_q <= href;

        if (!rst_n) begin
            state_q      <= RESET_STATE;
            skip_cnt_q   <= '0;
            mode_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            col_q        <= '0;
            line_q       <= '0;
            addr_q       <= '0;
            err_acc_q    <= 1'b0;
            wr_q         <= 1'b0;
            pix_addr_q   <= '0;
            pix_data_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            wr_q         <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                ST_SKIP: begin
                    if (end_frame) begin
                        skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
                        if (skip_cnt_q == SKIP_LAST) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_IDLE: begin
                    if (start_frame && enable) begin
                        state_q   <= ST_CAPTURE;
                        mode_q    <= mode;
                        addr_q    <= '0;
                        col_q     <= '0;
                        line_q    <= '0;
                        phase_q   <= 1'b0;
                        err_acc_q <= 1'b0;
                    end
                end

                ST_CAPTURE: begin
                    // End of frame takes priority over a byte in the same cycle.
                    if (end_frame) begin
                        frame_done_q <= 1'b1;
                        frame_err_q  <= err_acc_q | (line_q != LINE_FULL);
                        state_q      <= ST_IDLE;
                    end else if (line_end) begin
                        // A line must be exactly H_ACTIVE whole pixels. A
                        // dangling odd byte is discarded by clearing the phase.
                        line_q  <= line_inc_d;
                        col_q   <= '0;
                        phase_q <= 1'b0;
                        if ((col_q != COL_FULL) || phase_q) begin
                            err_acc_q <= 1'b1;
                        end
                    end else if (href) begin
                        if (!phase_q) begin
                            hi_q    <= pix_data_in;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            col_q   <= col_inc_d;
                            // Pixels outside the frame geometry are dropped.
                            // This keeps the address inside the buffer.
                            if (in_geom) begin
                                wr_q       <= 1'b1;
                                pix_addr_q <= addr_q;
                                pix_data_q <= pixel_d;
                                addr_q     <= addr_q + ADDR_W'(1);
                            end else begin
                                err_acc_q <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= RESET_STATE;
                end
            endcase
        end
    end

    assign wr           = wr_q;
    assign pix_addr     = pix_addr_q;
    assign pix_data_out = pix_data_q;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_cam_capture_gen.sv
// ---------------------------------------------------------------------------
// tb_cam_capture_gen
//
// Directed testbench for cam_capture_gen, with a 4x2 frame and one skipped
// start-up frame. The bench drives whole camera frames and collects every
// write and frame_done pulse. It then compares the collected results against
// hand-computed per-frame expectations.
// ---------------------------------------------------------------------------
module tb_cam_capture_gen;

    localparam int H_ACT  = 4;
    localparam int V_ACT  = 2;
    localparam int ADDR_W = 3;
    localparam int SKIP   = 1;

    logic              pclk = 1'b0;
    logic              rstN;
    logic              vsync;
    logic              href;
    logic [7:0]        pixDataIn;
    logic              enable;
    logic              mode;
    logic [ADDR_W-1:0] pixAddr;
    logic [15:0]       pixDataOut;
    logic              wr;
    logic              frameDone;
    logic              frameErr;

    int checks = 0;
    int errors = 0;

    cam_capture_gen #(
        .H_ACTIVE    (H_ACT),
        .V_ACTIVE    (V_ACT),
        .ADDR_W      (ADDR_W),
        .SKIP_FRAMES (SKIP)
    ) dut (
        .pclk         (pclk),
        .rst_n        (rstN),
        .vsync        (vsync),
        .href         (href),
        .pix_data_in  (pixDataIn),
        .enable       (enable),
        .mode         (mode),
        .pix_addr     (pixAddr),
        .pix_data_out (pixDataOut),
        .wr           (wr),
        .frame_done   (frameDone),
        .frame_err    (frameErr)
    );

    // 10-unit pixel clock
    always #5 pclk = ~pclk;

    // Rising-edge counter, used to measure write latency
    int cyc = 0;
    always @(posedge pclk) cyc++;

    // Write / frame_done collector, sampled mid-cycle
    int          wrCount;
    int          doneCount;
    int          firstWrCyc;
    int          backToBack = 0;
    int          lineStartCyc;
    int          frameFirstByteCyc;
    logic        prevWr = 1'b0;
    logic        errAtDone;
    int          wrAddr [64];
    logic [15:0] wrData [64];

    always @(negedge pclk) begin
        if (wr === 1'b1) begin
            if (wrCount < 64) begin
                wrAddr[wrCount] = int'(pixAddr);
                wrData[wrCount] = pixDataOut;
            end
            if (wrCount == 0) firstWrCyc = cyc;
            wrCount++;
            if (prevWr) backToBack++;
        end
        prevWr = (wr === 1'b1);
        if (frameDone === 1'b1) begin
            doneCount++;
            errAtDone = frameErr;
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: observed no finish, expected finish before limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic clearMonitor();
        wrCount    = 0;
        doneCount  = 0;
        firstWrCyc = 0;
        errAtDone  = 1'b0;
    endtask

    // One comparison: the count is bumped and the result asserted
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one href burst of nBytes, alternating b0/b1, then 3 idle cycles
    task automatic sendLine(input int nBytes, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < nBytes; i++) begin
            @(negedge pclk);
            if (i == 0) lineStartCyc = cyc;
            href      = 1'b1;
            pixDataIn = (i % 2 == 0) ? b0 : b1;
        end
        @(negedge pclk);
        href      = 1'b0;
        pixDataIn = 8'h00;
        tick(2);
    endtask

    // Drive one whole frame: vsync fall, lines, vsync rise, trailing blanking
    task automatic applyStimulus(input int nLines, input int bytesFirst, input int bytesRest,
                                 input logic [7:0] b0, input logic [7:0] b1,
                                 input bit toggleMode);
        clearMonitor();
        @(negedge pclk);
        vsync = 1'b0;
        tick(4);
        for (int l = 0; l < nLines; l++) begin
            sendLine((l == 0) ? bytesFirst : bytesRest, b0, b1);
            if (l == 0) begin
                frameFirstByteCyc = lineStartCyc;
                if (toggleMode) mode = ~mode;
            end
        end
        tick(2);
        @(negedge pclk);
        vsync = 1'b1;
        tick(8);
    endtask

    // Compare the collected frame result against expectations
    task automatic checkFrame(input string tag, input int expWr, input int expDone,
                              input logic expErr, input logic [15:0] expData);
        int badAddr;
        int badData;
        badAddr = 0;
        badData = 0;
        checkOutput({tag, "/wrCount"}, wrCount, expWr);
        checkOutput({tag, "/doneCount"}, doneCount, expDone);
        if (expDone > 0) checkOutput({tag, "/frameErr"}, 32'(errAtDone), 32'(expErr));
        if (expWr > 0) begin
            for (int i = 0; i < wrCount && i < 64; i++) begin
                if (wrAddr[i] != i) badAddr++;
                if (wrData[i] !== expData) badData++;
            end
            checkOutput({tag, "/badAddr"}, badAddr, 0);
            checkOutput({tag, "/badData"}, badData, 0);
        end
    endtask

    initial begin
        rstN      = 1'b0;
        vsync     = 1'b1;
        href      = 1'b0;
        pixDataIn = 8'h00;
        enable    = 1'b1;
        mode      = 1'b0;
        clearMonitor();
        tick(5);

        $display("[TB] reset state");
        checkOutput("reset/wr", 32'(wr), 32'(1'b0));
        checkOutput("reset/pixAddr", 32'(pixAddr), 32'(0));
        checkOutput("reset/pixData", 32'(pixDataOut), 32'(0));
        checkOutput("reset/frameDone", 32'(frameDone), 32'(1'b0));
        checkOutput("reset/frameErr", 32'(frameErr), 32'(1'b0));

        @(negedge pclk);
        rstN = 1'b1;
        tick(3);

        $display("[TB] start-up frame is skipped");
        applyStimulus(2, 8, 8, 8'h0A, 8'h5C, 1'b0);
        checkFrame("skipFrame", 0, 0, 1'b0, 16'h0000);

        $display("[TB] RGB444 frame");
        applyStimulus(2, 8, 8, 8'h0A, 8'h5C, 1'b0);
        checkFrame("rgb444", 8, 1, 1'b0, 16'h0A5C);
        checkOutput("rgb444/latency", firstWrCyc - frameFirstByteCyc, 2);

        $display("[TB] RGB565 frame with mode toggled mid-frame");
        mode = 1'b1;
        applyStimulus(2, 8, 8, 8'hF8, 8'h1F, 1'b1);
        checkFrame("rgb565", 8, 1, 1'b0, 16'hF81F);

        $display("[TB] 5-pixel line, new mode takes effect");
        applyStimulus(2, 10, 8, 8'hF8, 8'h1F, 1'b0);
        checkFrame("longLine", 8, 1, 1'b1, 16'h081F);

        $display("[TB] 3-pixel line");
        applyStimulus(2, 6, 8, 8'h0A, 8'h5C, 1'b0);
        checkFrame("shortLine", 7, 1, 1'b1, 16'h0A5C);

        $display("[TB] odd byte count");
        applyStimulus(2, 9, 8, 8'h0A, 8'h5C, 1'b0);
        checkFrame("oddBytes", 8, 1, 1'b1, 16'h0A5C);

        $display("[TB] three-line frame");
        applyStimulus(3, 8, 8, 8'h0A, 8'h5C, 1'b0);
        checkFrame("threeLines", 8, 1, 1'b1, 16'h0A5C);

        $display("[TB] one-line frame");
        applyStimulus(1, 8, 8, 8'h0A, 8'h5C, 1'b0);
        checkFrame("oneLine", 4, 1, 1'b1, 16'h0A5C);

        $display("[TB] enable low at frame start");
        enable = 1'b0;
        applyStimulus(2, 8, 8, 8'h0A, 8'h5C, 1'b0);
        enable = 1'b1;
        checkFrame("disabled", 0, 0, 1'b0, 16'h0000);
        checkOutput("disabled/errHold", 32'(frameErr), 32'(1'b1));

        $display("[TB] reset in the middle of a captured frame");
        clearMonitor();
        @(negedge pclk);
        vsync = 1'b0;
        tick(4);
        sendLine(8, 8'h0A, 8'h5C);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            href      = 1'b1;
            pixDataIn = (i % 2 == 0) ? 8'h0A : 8'h5C;
        end
        @(negedge pclk);
        rstN = 1'b0;
        @(negedge pclk);
        checkOutput("abort/wr", 32'(wr), 32'(1'b0));
        checkOutput("abort/pixAddr", 32'(pixAddr), 32'(0));
        checkOutput("abort/pixData", 32'(pixDataOut), 32'(0));
        checkOutput("abort/frameDone", 32'(frameDone), 32'(1'b0));
        checkOutput("abort/frameErr", 32'(frameErr), 32'(1'b0));
        href      = 1'b0;
        pixDataIn = 8'h00;
        vsync     = 1'b1;
        tick(4);
        checkOutput("abort/noDone", doneCount, 0);
        @(negedge pclk);
        rstN = 1'b1;
        tick(3);

        applyStimulus(2, 8, 8, 8'h0A, 8'h5C, 1'b0);
        checkFrame("postResetSkip", 0, 0, 1'b0, 16'h0000);

        applyStimulus(2, 8, 8, 8'h0A, 8'h5C, 1'b0);
        checkFrame("postResetCapture", 8, 1, 1'b0, 16'h0A5C);

        checkOutput("wrSpacing/backToBack", backToBack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
